// File: rtl/output_port_arbiter.sv
// Packet-level round-robin allocator for one router output port: locks the port
// to one input from head to tail and throttles pushes on output buffer occupancy.
module output_port_arbiter #(
  parameter int NUM_IN    = 5,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IN-1:0]     req,
  input  logic [2*NUM_IN-1:0]   req_type,
  input  logic [CNT_W-1:0]      out_count,
  output logic [NUM_IN-1:0]     grant,
  output logic                  alloc,
  output logic                  push,
  output logic [NUM_IN-1:0]     pop_in,
  output logic                  err_proto
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr;
  logic               r_first;
  logic [NUM_IN-1:0]  r_grant;
  logic               r_alloc;
  logic               r_err;

  logic               w_full;
  logic [NUM_IN-1:0]  w_elig;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [1:0]         w_own_type;
  logic               w_own_req;
  logic               w_push;

  assign w_full = (out_count == CNT_W'(BUF_DEPTH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_elig
      assign w_elig[gi] = req[gi] & (req_type[2*gi +: 2] == 2'b01);
    end
  endgenerate

  // Descending scan so the candidate closest to r_rr is the last one written.
  always_comb begin
    logic [IDX_W-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      idx = IDX_W'((int'(r_rr) + k) % NUM_IN);
      if (w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_own_type = req_type[2*r_owner +: 2];
  assign w_own_req  = req[r_owner];
  assign w_push     = !reset && (r_state == S_LOCKED) && w_own_req &&
                      (w_own_type != 2'b00) && !w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_first <= 1'b0;
      r_grant <= '0;
      r_alloc <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // A head after the first push, or a non-head as the first push, is flagged but still forwarded.
      r_err <= w_push && (r_first ? (w_own_type != 2'b01) : (w_own_type == 2'b01));
      case (r_state)
        S_IDLE: begin
          if (w_found && !w_full) begin
            r_owner <= w_win;
            r_grant <= NUM_IN'(1) << w_win;
            r_alloc <= 1'b1;
            r_first <= 1'b1;
            r_state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (w_push) begin
            r_first <= 1'b0;
            if (w_own_type == 2'b11) begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_alloc <= 1'b0;
              r_rr    <= (r_owner == IDX_W'(NUM_IN-1)) ? '0 : r_owner + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign alloc     = r_alloc;
  assign err_proto = r_err;
  assign push      = w_push;
  assign pop_in    = r_grant & {NUM_IN{w_push}};

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Packet-level round-robin allocator for one router output port.
- Shares the port among NUM_IN input units.
- Locks the port to one input from head flit to tail flit.
- Drives the push strobe and alloc flag into the output unit, and throttles on that unit's buffer occupancy so no flit is pushed into a full output buffer.

Parameters:
NUM_IN, 5, number of requesting input ports (N, E, S, W, local)
BUF_DEPTH, 4, output unit buffer depth in flits
CNT_W, 3, width of occupancy input; must hold 0..BUF_DEPTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, synchronous, active-high
req  input  NUM_IN  input i holds a flit destined for this output
req_type  input  2*NUM_IN  flit type bits [63:62] of input i's head-of-queue flit, slice [2i+1:2i]
out_count  input  CNT_W  registered occupancy of the output unit buffer
grant  output  NUM_IN  one-hot owner of the port; all zero when free
alloc  output  1  port allocated (to output unit alloc)
push  output  1  transfer owner's flit into output buffer this cycle
pop_in  output  NUM_IN  one-hot dequeue strobe to the owner input; equals grant & {NUM_IN{push}}
err_proto  output  1  one-cycle pulse on protocol violation

Behaviour:
- Flit types: 00 invalid, 01 head, 10 body, 11 tail. Packets are head, zero or more body, then tail. Minimum packet length is 2 flits.
- full = (out_count == BUF_DEPTH).
- State: FSM {IDLE, LOCKED}, owner index, round-robin pointer rr_ptr (0..NUM_IN-1).
- Reset: state=IDLE, grant=0, alloc=0, rr_ptr=0, err_proto=0. push and pop_in are 0 combinationally.
  - Reset mid-packet discards the lock with no tail required.
  - Inputs are cleared by their own reset.
- Eligibility: input i is eligible iff req[i]=1 and its type=01.
- IDLE:
  - push=0.
  - If any input is eligible and !full, on the edge:
    - select the first eligible input scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_IN;
    - owner<=winner, grant<=onehot(winner), alloc<=1, state<=LOCKED.
  - Otherwise, stay in IDLE.
  - Requests with type 10/11 in IDLE are ignored, no error.
- LOCKED:
  - push = req[owner] & (req_type[owner]!=00) & !full, combinational.
  - Non-owner requests are ignored.
  - On an edge with push=1 and owner type=11: state<=IDLE, grant<=0, alloc<=0, rr_ptr<=(owner+1) mod NUM_IN.
  - The port is free the cycle after the tail. New arbitration can win on that edge's successor, so there is at least one idle cycle between packets.
- Latency: eligible head at cycle t (port free, not full) → grant at t+1 → head push at t+1 if still requesting and !full.
- Throttling: while full, push=0 and the lock is held indefinitely. There is no timeout.
- Protocol errors: err_proto is registered, pulsing high the cycle after any of these:
  - a push with owner type=01 other than the first push of the lock. The flit is still forwarded and the lock is unchanged.
  - the first push of a lock carrying type 10 or 11. The flit is forwarded and a tail still ends the lock.
- Simultaneous events:
  - A tail push and a new eligible head on the same edge: the tail releases; the new head is considered next cycle.
  - out_count decreasing on the same edge as a push has no effect, since full is evaluated from the current out_count only.
- grant is always one-hot or zero. alloc == |grant.

Test Plan:
1. Reset, then req=00001 with type 01 and out_count=0 at cycle 1 → grant=00001, alloc=1 at cycle 2; push=1 for a 3-flit packet (01,10,11) on cycles 2–4; grant=0 at cycle 5; rr_ptr=1.
2. All 5 inputs requesting heads continuously with 2-flit packets → grant order 0,1,2,3,4,0; each packet occupies 3 cycles (2 push + 1 idle).
3. Owner 2 mid-packet with out_count=4 for 3 cycles → push=0 for those cycles, grant stays 00100; push resumes when out_count=3; no flit lost; input 3 head waits.
4. Owner sends 01,10,01,11 → err_proto=1 exactly one cycle after the second head push; all 4 flits pushed; lock released after the tail.
5. Reset asserted mid-packet with grant=01000 → next cycle grant=0, alloc=0, push=0, rr_ptr=0; input 0 head then wins first.
6. Owner req drops to 0 for 2 cycles mid-packet → push=0 and grant held; req restored with tail → push=1, release.
